vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder_if.sv | 35 +++
 rtl/vga_sync_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_decoder_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : vga_sync_decoder_if
// Description : Bundle of the raw VGA sync pins and the decoded timing
//               outputs exchanged between a sync source and the decoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface vga_sync_decoder_if;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       new_line;
    logic       new_frame;
    logic       locked;
    logic       sync_err;

    // Sync source side: drives the pins, observes the decoded timing
    modport master (
        output hsync_in, vsync_in,
        input  x, y, active, line_len, frame_lines,
        input  new_line, new_frame, locked, sync_err
    );

    // Decoder side
    modport slave (
        input  hsync_in, vsync_in,
        output x, y, active, line_len, frame_lines,
        output new_line, new_frame, locked, sync_err
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : vga_sync_decoder
// Description : Recovers pixel coordinates from asynchronous VGA hsync/vsync,
//               measures line and frame lengths and tracks lock against the
//               configured timing.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter bit SYNC_POL = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    vga_sync_decoder_if.slave bus
);

    // Comparisons are done at 11 bits so a saturated count (1023) plus one
    // never aliases onto a legal total.
    localparam logic [10:0] c_h_total = 11'(H_TOTAL);
    localparam logic [10:0] c_v_total = 11'(V_TOTAL);
    localparam logic [10:0] c_h_start = 11'(H_SYNC + H_BP);
    localparam logic [10:0] c_h_end   = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] c_v_start = 11'(V_SYNC + V_BP);
    localparam logic [10:0] c_v_end   = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0]  c_cnt_max = 10'd1023;
    localparam logic [9:0]  c_cnt_pre = 10'd1022;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // [0],[1] synchronizer, [2] edge-detect history; 1 = asserted
    logic [2:0]  r_hs_sync;
    logic [2:0]  r_vs_sync;

    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic [9:0]  r_line_len;
    logic [9:0]  r_frame_lines;
    logic        r_new_line;
    logic        r_new_frame;

    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_active;

    state_t      r_state;
    logic        r_locked;
    logic        r_sync_err;
    logic        r_frame_bad;

    logic        w_h_edge;
    logic        w_v_edge;
    logic [10:0] w_hcount_inc;
    logic [10:0] w_vcount_inc;
    logic        w_h_line_bad;
    logic        w_v_frame_bad;
    logic        w_h_sat;
    logic        w_v_sat;
    logic        w_in_h;
    logic        w_in_v;

    assign w_h_edge      = r_hs_sync[1] & ~r_hs_sync[2];
    assign w_v_edge      = r_vs_sync[1] & ~r_vs_sync[2];
    assign w_hcount_inc  = {1'b0, r_hcount} + 11'd1;
    assign w_vcount_inc  = {1'b0, r_vcount} + 11'd1;
    assign w_h_line_bad  = w_h_edge && (w_hcount_inc != c_h_total);
    assign w_v_frame_bad = w_v_edge && (w_vcount_inc != c_v_total);
    // Saturation flags fire on the clock that moves a counter onto 1023
    assign w_h_sat       = !w_h_edge && (r_hcount == c_cnt_pre);
    assign w_v_sat       = w_h_edge && !w_v_edge && (r_vcount == c_cnt_pre);
    assign w_in_h        = ({1'b0, r_hcount} >= c_h_start) && ({1'b0, r_hcount} < c_h_end);
    assign w_in_v        = ({1'b0, r_vcount} >= c_v_start) && ({1'b0, r_vcount} < c_v_end);

    // Bring the sync pins into clk, normalise polarity, keep edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_sync <= '0;
            r_vs_sync <= '0;
        end else begin
            r_hs_sync <= {r_hs_sync[1:0], bus.hsync_in ^ ~SYNC_POL};
            r_vs_sync <= {r_vs_sync[1:0], bus.vsync_in ^ ~SYNC_POL};
        end
    end

    // Pixel/line counters, length measurements and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_new_line    <= 1'b0;
            r_new_frame   <= 1'b0;
        end else begin
            r_new_line  <= w_h_edge;
            r_new_frame <= w_v_edge;

            if (w_h_edge) begin
                r_hcount   <= '0;
                r_line_len <= w_hcount_inc[9:0];
            end else if (r_hcount != c_cnt_max) begin
                r_hcount <= r_hcount + 10'd1;
            end

            // vsync restart overrides the per-line increment
            if (w_v_edge) begin
                r_vcount      <= '0;
                r_frame_lines <= w_vcount_inc[9:0];
            end else if (w_h_edge && (r_vcount != c_cnt_max)) begin
                r_vcount <= r_vcount + 10'd1;
            end
        end
    end

    // Coordinates of the current pixel, gated by lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_active <= 1'b0;
        end else if (r_locked && w_in_h && w_in_v) begin
            r_x      <= r_hcount - c_h_start[9:0];
            r_y      <= r_vcount - c_v_start[9:0];
            r_active <= 1'b1;
        end else begin
            r_x      <= '0;
            r_y      <= '0;
            r_active <= 1'b0;
        end
    end

    // Lock tracker: one clean frame in CHECK is required before LOCKED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SEARCH;
            r_locked    <= 1'b0;
            r_sync_err  <= 1'b0;
            r_frame_bad <= 1'b0;
        end else begin
            r_sync_err <= 1'b0;
            if (w_v_edge) begin
                r_frame_bad <= 1'b0;
            end
            case (r_state)
                S_SEARCH: begin
                    if (w_v_edge) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_h_sat || w_v_sat) begin
                        r_state <= S_SEARCH;
                    end else if (w_v_edge) begin
                        // The line closed by a coincident hsync edge still counts
                        if (!r_frame_bad && !w_h_line_bad && !w_v_frame_bad) begin
                            r_state  <= S_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else if (w_h_line_bad) begin
                        r_frame_bad <= 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (w_h_line_bad || w_v_frame_bad || w_h_sat || w_v_sat) begin
                        r_state    <= S_SEARCH;
                        r_locked   <= 1'b0;
                        r_sync_err <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.active      = r_active;
    assign bus.line_len    = r_line_len;
    assign bus.frame_lines = r_frame_lines;
    assign bus.new_line    = r_new_line;
    assign bus.new_frame   = r_new_frame;
    assign bus.locked      = r_locked;
    assign bus.sync_err    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_vga_sync_decoder
// Description : Randomized self-checking bench for vga_sync_decoder using a
//               reduced raster and a cycle-level reference model of the
//               decoding rules.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_vga_sync_decoder;

    // Reduced raster keeps every scenario within a short run
    localparam int P_H_SYNC   = 2;
    localparam int P_H_BP     = 3;
    localparam int P_H_ACTIVE = 16;
    localparam int P_H_TOTAL  = 24;
    localparam int P_V_SYNC   = 1;
    localparam int P_V_BP     = 2;
    localparam int P_V_ACTIVE = 8;
    localparam int P_V_TOTAL  = 14;
    localparam bit P_POL      = 1'b0;

    localparam int M_SEARCH = 0;
    localparam int M_CHECK  = 1;
    localparam int M_LOCKED = 2;

    logic clk = 1'b0;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    vga_sync_decoder_if vif ();

    vga_sync_decoder #(
        .H_SYNC   (P_H_SYNC),
        .H_BP     (P_H_BP),
        .H_ACTIVE (P_H_ACTIVE),
        .H_TOTAL  (P_H_TOTAL),
        .V_SYNC   (P_V_SYNC),
        .V_BP     (P_V_BP),
        .V_ACTIVE (P_V_ACTIVE),
        .V_TOTAL  (P_V_TOTAL),
        .SYNC_POL (P_POL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.slave)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    bit hist_h [0:2];
    bit hist_v [0:2];
    int m_h, m_v, m_state;
    bit m_bad;
    int e_x, e_y, e_line_len, e_frame_lines;
    bit e_active, e_new_line, e_new_frame, e_locked, e_sync_err;

    // scenario observation
    int err_seen;
    int act_seen;
    int first_x, first_y, last_x, last_y;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic lvl(input bit asserted);
        return asserted ? P_POL : ~P_POL;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist_h[i] = 1'b0;
            hist_v[i] = 1'b0;
        end
        m_h = 0; m_v = 0; m_state = M_SEARCH; m_bad = 1'b0;
        e_x = 0; e_y = 0; e_line_len = 0; e_frame_lines = 0;
        e_active = 1'b0; e_new_line = 1'b0; e_new_frame = 1'b0;
        e_locked = 1'b0; e_sync_err = 1'b0;
    endtask

    // One rising edge of the model, given the pin levels seen at that edge
    task automatic model_edge(input logic hp, input logic vp);
        bit hl, vl, h_bad, v_bad, h_sat, v_sat, old_bad, in_view;
        hl = hist_h[1] && !hist_h[2];
        vl = hist_v[1] && !hist_v[2];

        in_view = (m_h >= P_H_SYNC + P_H_BP) && (m_h < P_H_SYNC + P_H_BP + P_H_ACTIVE) &&
                  (m_v >= P_V_SYNC + P_V_BP) && (m_v < P_V_SYNC + P_V_BP + P_V_ACTIVE);
        if (e_locked && in_view) begin
            e_x = m_h - (P_H_SYNC + P_H_BP);
            e_y = m_v - (P_V_SYNC + P_V_BP);
            e_active = 1'b1;
        end else begin
            e_x = 0; e_y = 0; e_active = 1'b0;
        end

        e_new_line  = hl;
        e_new_frame = vl;
        if (hl) e_line_len    = (m_h + 1) % 1024;
        if (vl) e_frame_lines = (m_v + 1) % 1024;

        h_bad = hl && (m_h + 1 != P_H_TOTAL);
        v_bad = vl && (m_v + 1 != P_V_TOTAL);
        h_sat = !hl && (m_h == 1022);
        v_sat = hl && !vl && (m_v == 1022);

        old_bad = m_bad;
        if (vl) m_bad = 1'b0;
        e_sync_err = 1'b0;
        if (m_state == M_SEARCH) begin
            if (vl) m_state = M_CHECK;
        end else if (m_state == M_CHECK) begin
            if (h_sat || v_sat)                           m_state = M_SEARCH;
            else if (vl && !old_bad && !h_bad && !v_bad)  m_state = M_LOCKED;
            else if (!vl && h_bad)                        m_bad = 1'b1;
        end else begin
            if (h_bad || v_bad || h_sat || v_sat) begin
                m_state = M_SEARCH;
                e_sync_err = 1'b1;
            end
        end
        e_locked = (m_state == M_LOCKED);

        m_v = vl ? 0 : (hl ? ((m_v < 1023) ? m_v + 1 : 1023) : m_v);
        m_h = hl ? 0 : ((m_h < 1023) ? m_h + 1 : 1023);

        hist_h[2] = hist_h[1]; hist_h[1] = hist_h[0]; hist_h[0] = (hp == P_POL);
        hist_v[2] = hist_v[1]; hist_v[1] = hist_v[0]; hist_v[0] = (vp == P_POL);
    endtask

    function automatic logic [63:0] exp_vec();
        return 64'({10'(e_x), 10'(e_y), e_active, 10'(e_line_len), 10'(e_frame_lines),
                    e_new_line, e_new_frame, e_locked, e_sync_err});
    endfunction

    function automatic logic [63:0] obs_vec();
        return 64'({vif.x, vif.y, vif.active, vif.line_len, vif.frame_lines,
                    vif.new_line, vif.new_frame, vif.locked, vif.sync_err});
    endfunction

    // Drive pins, clock once, compare every output against the model
    task automatic step(input logic hp, input logic vp);
        vif.hsync_in = hp;
        vif.vsync_in = vp;
        @(posedge clk);
        if (rst_n) model_edge(hp, vp);
        else       model_reset();
        @(negedge clk);
        chk("outputs", obs_vec(), exp_vec());
        if (vif.sync_err) err_seen++;
        if (vif.new_frame) chk("coincident_new_line", 64'(vif.new_line), 64'd1);
        if (vif.active) begin
            act_seen++;
            if (first_x < 0) begin
                first_x = int'(vif.x);
                first_y = int'(vif.y);
            end
            last_x = int'(vif.x);
            last_y = int'(vif.y);
        end
    endtask

    task automatic play_line(input int len, input bit vs_on);
        for (int p = 0; p < len; p++) step(lvl(p < P_H_SYNC), lvl(vs_on));
    endtask

    task automatic play_lines(input int first, input int stop, input int odd_line, input int odd_len);
        for (int l = first; l < stop; l++)
            play_line((l == odd_line) ? odd_len : P_H_TOTAL, l < P_V_SYNC);
    endtask

    task automatic play_frame();
        play_lines(0, P_V_TOTAL, -1, 0);
    endtask

    task automatic clear_obs();
        err_seen = 0; act_seen = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_x"},           64'(vif.x), 64'd0);
        chk({pfx, "_y"},           64'(vif.y), 64'd0);
        chk({pfx, "_active"},      64'(vif.active), 64'd0);
        chk({pfx, "_line_len"},    64'(vif.line_len), 64'd0);
        chk({pfx, "_frame_lines"}, 64'(vif.frame_lines), 64'd0);
        chk({pfx, "_new_line"},    64'(vif.new_line), 64'd0);
        chk({pfx, "_new_frame"},   64'(vif.new_frame), 64'd0);
        chk({pfx, "_locked"},      64'(vif.locked), 64'd0);
        chk({pfx, "_sync_err"},    64'(vif.sync_err), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int odd_line, odd_len, nl, cut;
        rst_n = 1'b0;
        vif.hsync_in = lvl(1'b0);
        vif.vsync_in = lvl(1'b0);
        model_reset();
        clear_obs();
        for (int i = 0; i < 4; i++) step(lvl(1'b0), lvl(1'b0));
        check_all_zero("reset");
        rst_n = 1'b1;

        // Nominal timing: lock is taken on the second vsync edge
        play_frame();
        chk("locked_after_frame1", 64'(vif.locked), 64'd0);
        play_frame();
        chk("locked_after_frame2", 64'(vif.locked), 64'd1);
        clear_obs();
        play_frame();
        chk("line_len_nominal",    64'(vif.line_len), 64'(P_H_TOTAL));
        chk("frame_lines_nominal", 64'(vif.frame_lines), 64'(P_V_TOTAL));
        chk("active_pixels",       64'(act_seen), 64'(P_H_ACTIVE * P_V_ACTIVE));
        chk("first_pixel_x",       64'(first_x), 64'd0);
        chk("first_pixel_y",       64'(first_y), 64'd0);
        chk("last_pixel_x",        64'(last_x), 64'(P_H_ACTIVE - 1));
        chk("last_pixel_y",        64'(last_y), 64'(P_V_ACTIVE - 1));

        // One wrong-length line while locked, then relock
        for (int it = 0; it < 3; it++) begin
            odd_line = 1 + int'($urandom_range(P_V_TOTAL - 3));
            if (it == 0) odd_len = P_H_TOTAL - 1;
            else begin
                do odd_len = int'($urandom_range(P_H_TOTAL + 8, P_H_SYNC + 2));
                while (odd_len == P_H_TOTAL);
            end
            clear_obs();
            play_lines(0, P_V_TOTAL, odd_line, odd_len);
            chk("bad_line_sync_err_count", 64'(err_seen), 64'd1);
            chk("bad_line_locked",         64'(vif.locked), 64'd0);
            play_frame();
            chk("bad_line_relock_1", 64'(vif.locked), 64'd0);
            play_frame();
            chk("bad_line_relock_2", 64'(vif.locked), 64'd1);
        end

        // Wrong number of lines in a frame while locked
        nl = ($urandom_range(1) == 0) ? P_V_TOTAL - 1 : P_V_TOTAL + 1;
        clear_obs();
        play_lines(0, nl, -1, 0);
        play_frame();
        chk("bad_frame_sync_err_count", 64'(err_seen), 64'd1);
        chk("bad_frame_locked",         64'(vif.locked), 64'd0);
        play_frame();
        play_frame();
        chk("bad_frame_relock", 64'(vif.locked), 64'd1);

        // hsync lost mid-frame while locked
        clear_obs();
        play_lines(0, 5, -1, 0);
        for (int i = 0; i < 1100; i++) step(lvl(1'b0), lvl(1'b0));
        chk("hsync_lost_sync_err_count", 64'(err_seen), 64'd1);
        chk("hsync_lost_locked",         64'(vif.locked), 64'd0);
        play_frame();
        play_frame();
        chk("hsync_lost_relock", 64'(vif.locked), 64'd1);

        // Asynchronous reset mid-frame while locked
        cut = 1 + int'($urandom_range(P_V_TOTAL - 2));
        play_lines(0, cut, -1, 0);
        chk("pre_reset_locked", 64'(vif.locked), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        for (int i = 0; i < 3; i++) step(lvl(1'b0), lvl(1'b0));
        rst_n = 1'b1;
        play_lines(cut, P_V_TOTAL, -1, 0);
        play_frame();
        chk("reset_relock_1", 64'(vif.locked), 64'd0);
        play_frame();
        chk("reset_relock_2", 64'(vif.locked), 64'd1);

        // vsync lost while locked: vcount saturates
        clear_obs();
        play_lines(0, P_V_TOTAL, -1, 0);
        play_lines(P_V_SYNC, P_V_SYNC + 1030, -1, 0);
        chk("vsync_lost_sync_err_count", 64'(err_seen), 64'd1);
        chk("vsync_lost_locked",         64'(vif.locked), 64'd0);
        play_frame();
        play_frame();
        chk("vsync_lost_relock", 64'(vif.locked), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
